regfile_scoreboard: RTL and testbench

//  Parametrised architectural register file with a per-entry busy (scoreboard) bit.
//  - DEPTH x WIDTH storage; NUM_RD combinational read ports; one write/writeback port.
//  - Allocate port marks a destination busy at issue; writeback clears it.
//  - Sits between decode/issue (reads + allocate) and the writeback stage.

---
 rtl/regfile_scoreboard_if.sv | 29 ++
 rtl/regfile_scoreboard.sv | 73 +++++++
 tb/tb_regfile_scoreboard.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/regfile_scoreboard_if.sv
// Register file / scoreboard bus: writeback, allocate and read ports.
// master = issue/writeback side, slave = register file.
interface regfile_scoreboard_if #(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned DEPTH  = 32,
  parameter int unsigned NUM_RD = 2
);
  localparam int unsigned AW = $clog2(DEPTH);

  logic                              wr_en;
  logic [AW-1:0]                     wr_addr;
  logic [WIDTH-1:0]                  wr_data;
  logic                              alloc_en;
  logic [AW-1:0]                     alloc_addr;
  logic [NUM_RD-1:0][AW-1:0]         rd_addr;
  logic [NUM_RD-1:0][WIDTH-1:0]      rd_data;
  logic [NUM_RD-1:0]                 rd_busy;
  logic                              any_busy;

  modport master (
    output wr_en, wr_addr, wr_data, alloc_en, alloc_addr, rd_addr,
    input  rd_data, rd_busy, any_busy
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, alloc_en, alloc_addr, rd_addr,
    output rd_data, rd_busy, any_busy
  );
endinterface

// File: rtl/regfile_scoreboard.sv
// Architectural register file with a per-entry busy (scoreboard) bit.
// Combinational read ports, one writeback port, one allocate port.
// Optional feature macro: REGFILE_BYPASS_EN (same-cycle write-to-read forwarding).
module regfile_scoreboard #(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned DEPTH    = 32,
  parameter int unsigned NUM_RD   = 2,
  parameter int unsigned ZERO_REG = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  regfile_scoreboard_if.slave  rf
);
  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0]             regs [DEPTH];
  logic [DEPTH-1:0]             busy;
  logic [DEPTH-1:0]             busy_next;
  logic                         any_busy_q;
  logic                         wr_ok;
  logic                         alloc_ok;
  logic [AW-1:0]                ra;
  logic [NUM_RD-1:0][WIDTH-1:0] rd_data_c;
  logic [NUM_RD-1:0]            rd_busy_c;

  // Register 0 swallows writes/allocates when it is hardwired to zero.
  assign wr_ok    = rf.wr_en    && !((ZERO_REG != 0) && (rf.wr_addr    == '0));
  assign alloc_ok = rf.alloc_en && !((ZERO_REG != 0) && (rf.alloc_addr == '0));

  // Next busy vector: writeback clears, allocate sets; allocate applied last so the new producer wins.
  always_comb begin
    busy_next = busy;
    if (wr_ok)    busy_next[rf.wr_addr]    = 1'b0;
    if (alloc_ok) busy_next[rf.alloc_addr] = 1'b1;
  end

  // Storage, busy bits and the registered any_busy summary.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) regs[i] <= '0;
      busy       <= '0;
      any_busy_q <= 1'b0;
    end else begin
      if (wr_ok) regs[rf.wr_addr] <= rf.wr_data;
      busy       <= busy_next;
      any_busy_q <= |busy_next;
    end
  end

  // Combinational read ports, with optional forwarding of the in-flight write.
  always_comb begin
    rd_data_c = '0;
    rd_busy_c = '0;
    ra        = '0;
    for (int unsigned k = 0; k < NUM_RD; k++) begin
      ra = rf.rd_addr[k];
      if (!((ZERO_REG != 0) && (ra == '0))) begin
        rd_data_c[k] = regs[ra];
        rd_busy_c[k] = busy[ra];
`ifdef REGFILE_BYPASS_EN
        if (wr_ok && (rf.wr_addr == ra)) begin
          rd_data_c[k] = rf.wr_data;
          rd_busy_c[k] = alloc_ok && (rf.alloc_addr == ra);
        end
`endif
      end
    end
  end

  assign rf.rd_data  = rd_data_c;
  assign rf.rd_busy  = rd_busy_c;
  assign rf.any_busy = any_busy_q;
endmodule

// File: tb/tb_regfile_scoreboard.sv
// Bench for regfile_scoreboard: directed scenarios plus random traffic
// checked against an array-based model of the register file semantics.
module tb_regfile_scoreboard;
  localparam int unsigned WIDTH  = 32;
  localparam int unsigned DEPTH  = 32;
  localparam int unsigned NUM_RD = 2;

  logic clk = 1'b0;
  logic reset;

  regfile_scoreboard_if #(.WIDTH(WIDTH), .DEPTH(DEPTH), .NUM_RD(NUM_RD)) rf_if ();

  regfile_scoreboard #(
    .WIDTH(WIDTH), .DEPTH(DEPTH), .NUM_RD(NUM_RD), .ZERO_REG(1)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .rf    (rf_if)
  );

  always #5 clk = ~clk;

  logic [WIDTH-1:0] m_regs [DEPTH];
  bit               m_busy [DEPTH];
  int               n_checks = 0;
  int               n_fail   = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Expected read data for port k given model state and current inputs.
  function automatic logic [WIDTH-1:0] exp_data(input int k);
    int a;
    a = int'(rf_if.rd_addr[k]);
    if (a == 0) return '0;
`ifdef REGFILE_BYPASS_EN
    if (rf_if.wr_en && int'(rf_if.wr_addr) == a) return rf_if.wr_data;
`endif
    return m_regs[a];
  endfunction

  function automatic bit exp_busy(input int k);
    int a;
    a = int'(rf_if.rd_addr[k]);
    if (a == 0) return 1'b0;
`ifdef REGFILE_BYPASS_EN
    if (rf_if.wr_en && int'(rf_if.wr_addr) == a)
      return rf_if.alloc_en && int'(rf_if.alloc_addr) == a;
`endif
    return m_busy[a];
  endfunction

  function automatic bit exp_any();
    bit r = 1'b0;
    for (int i = 0; i < int'(DEPTH); i++) r |= m_busy[i];
    return r;
  endfunction

  task automatic set_idle();
    rf_if.wr_en      = 1'b0;
    rf_if.wr_addr    = '0;
    rf_if.wr_data    = '0;
    rf_if.alloc_en   = 1'b0;
    rf_if.alloc_addr = '0;
    rf_if.rd_addr    = '0;
  endtask

  // Compare every output against the model at the falling edge.
  task automatic sample();
    @(negedge clk);
    for (int k = 0; k < int'(NUM_RD); k++) begin
      check_eq($sformatf("rd_data[%0d]", k), 64'(rf_if.rd_data[k]), 64'(exp_data(k)));
      check_eq($sformatf("rd_busy[%0d]", k), 64'(rf_if.rd_busy[k]), 64'(exp_busy(k)));
    end
    check_eq("any_busy", 64'(rf_if.any_busy), 64'(exp_any()));
  endtask

  // Clock edge: apply this cycle's inputs to the model.
  task automatic advance();
    @(posedge clk);
    if (reset) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        m_regs[i] = '0;
        m_busy[i] = 1'b0;
      end
    end else begin
      if (rf_if.wr_en && rf_if.wr_addr != 0) begin
        m_regs[rf_if.wr_addr] = rf_if.wr_data;
        m_busy[rf_if.wr_addr] = 1'b0;
      end
      if (rf_if.alloc_en && rf_if.alloc_addr != 0) m_busy[rf_if.alloc_addr] = 1'b1;
    end
    #1;
  endtask

  initial begin
    set_idle();
    reset = 1'b1;
    for (int i = 0; i < int'(DEPTH); i++) begin
      m_regs[i] = '0;
      m_busy[i] = 1'b0;
    end
    repeat (3) advance();
    reset = 1'b0;

    // Post-reset: everything zero and idle.
    for (int a = 0; a < 4; a++) begin
      rf_if.rd_addr[0] = 5'(a);
      rf_if.rd_addr[1] = 5'(a + 8);
      sample();
      check_eq("reset_any", 64'(rf_if.any_busy), 64'd0);
      advance();
    end

    // Write r5 then read it on both ports.
    rf_if.wr_en = 1'b1; rf_if.wr_addr = 5'd5; rf_if.wr_data = 32'hDEAD_BEEF;
    sample(); advance();
    set_idle(); rf_if.rd_addr[0] = 5'd5; rf_if.rd_addr[1] = 5'd5;
    sample();
    check_eq("r5_port0", 64'(rf_if.rd_data[0]), 64'h0000_0000_DEAD_BEEF);
    check_eq("r5_port1", 64'(rf_if.rd_data[1]), 64'h0000_0000_DEAD_BEEF);
    advance();

    // Allocate r7, then write it back.
    set_idle(); rf_if.alloc_en = 1'b1; rf_if.alloc_addr = 5'd7;
    sample(); advance();
    set_idle(); rf_if.rd_addr[0] = 5'd7;
    sample();
    check_eq("r7_busy", 64'(rf_if.rd_busy[0]), 64'd1);
    check_eq("r7_any", 64'(rf_if.any_busy), 64'd1);
    advance();
    rf_if.wr_en = 1'b1; rf_if.wr_addr = 5'd7; rf_if.wr_data = 32'h1234;
    sample(); advance();
    set_idle(); rf_if.rd_addr[0] = 5'd7;
    sample();
    check_eq("r7_wb_busy", 64'(rf_if.rd_busy[0]), 64'd0);
    check_eq("r7_wb_data", 64'(rf_if.rd_data[0]), 64'h1234);
    check_eq("r7_wb_any", 64'(rf_if.any_busy), 64'd0);
    advance();

    // Same-cycle alloc and write on r3: data lands, busy stays set.
    rf_if.alloc_en = 1'b1; rf_if.alloc_addr = 5'd3;
    rf_if.wr_en = 1'b1; rf_if.wr_addr = 5'd3; rf_if.wr_data = 32'h55;
    sample(); advance();
    set_idle(); rf_if.rd_addr[1] = 5'd3;
    sample();
    check_eq("r3_data", 64'(rf_if.rd_data[1]), 64'h55);
    check_eq("r3_busy", 64'(rf_if.rd_busy[1]), 64'd1);
    advance();

    // Register 0 ignores writes and allocates.
    rf_if.alloc_en = 1'b1; rf_if.alloc_addr = 5'd0;
    rf_if.wr_en = 1'b1; rf_if.wr_addr = 5'd0; rf_if.wr_data = 32'hFFFF_FFFF;
    sample(); advance();
    set_idle();
    sample();
    check_eq("r0_data", 64'(rf_if.rd_data[0]), 64'd0);
    check_eq("r0_busy", 64'(rf_if.rd_busy[0]), 64'd0);
    advance();

    // Same-cycle read of r9 while it is being written.
    rf_if.wr_en = 1'b1; rf_if.wr_addr = 5'd9; rf_if.wr_data = 32'h0000_0011;
    sample(); advance();
    set_idle(); rf_if.rd_addr[0] = 5'd9;
    rf_if.wr_en = 1'b1; rf_if.wr_addr = 5'd9; rf_if.wr_data = 32'hA5A5_A5A5;
    sample();
`ifdef REGFILE_BYPASS_EN
    check_eq("r9_same_cycle", 64'(rf_if.rd_data[0]), 64'hA5A5_A5A5);
`else
    check_eq("r9_same_cycle", 64'(rf_if.rd_data[0]), 64'h11);
`endif
    advance();
    set_idle(); rf_if.rd_addr[0] = 5'd9;
    sample();
    check_eq("r9_next_cycle", 64'(rf_if.rd_data[0]), 64'hA5A5_A5A5);
    advance();

    // Reset while r2 is busy with data; write during reset is ignored.
    rf_if.wr_en = 1'b1; rf_if.wr_addr = 5'd2; rf_if.wr_data = 32'h77;
    rf_if.alloc_en = 1'b1; rf_if.alloc_addr = 5'd2;
    sample(); advance();
    set_idle(); rf_if.rd_addr[0] = 5'd2;
    reset = 1'b1;
    rf_if.wr_en = 1'b1; rf_if.wr_addr = 5'd2; rf_if.wr_data = 32'h99;
    sample();
    check_eq("r2_pre_busy", 64'(rf_if.rd_busy[0]), 64'd1);
    advance();
    reset = 1'b0;
    set_idle(); rf_if.rd_addr[0] = 5'd2;
    sample();
    check_eq("r2_rst_data", 64'(rf_if.rd_data[0]), 64'd0);
    check_eq("r2_rst_busy", 64'(rf_if.rd_busy[0]), 64'd0);
    check_eq("r2_rst_any", 64'(rf_if.any_busy), 64'd0);
    advance();

    // Random traffic, addresses often confined to a small window for collisions.
    for (int n = 0; n < 600; n++) begin
      bit narrow;
      narrow = ($urandom_range(0, 1) == 1);
      reset            = ($urandom_range(0, 79) == 0);
      rf_if.wr_en      = ($urandom_range(0, 1) == 1);
      rf_if.wr_addr    = narrow ? 5'($urandom_range(0, 7)) : 5'($urandom);
      rf_if.wr_data    = 32'($urandom);
      rf_if.alloc_en   = ($urandom_range(0, 2) == 0);
      rf_if.alloc_addr = narrow ? 5'($urandom_range(0, 7)) : 5'($urandom);
      for (int k = 0; k < int'(NUM_RD); k++)
        rf_if.rd_addr[k] = narrow ? 5'($urandom_range(0, 7)) : 5'($urandom);
      if ($urandom_range(0, 3) == 0) rf_if.rd_addr[1] = rf_if.rd_addr[0];
      sample();
      advance();
    end

    reset = 1'b0;
    set_idle();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
